gcd_sequencer: RTL and testbench
================================

GCD_SEQUENCER -- requirements
Module: gcd_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4: operand-pair FIFO entries (power of 2, 2..16).
REQ-002 SHALL have parameter W, default 8: operand/result width, matched to the GCD engine.
REQ-003 SHALL have one clock; reset is synchronous and active-low. Ports are named Clk and Reset_n.
REQ-004 Clk  in  1  rising-edge clock for all state.
REQ-005 Reset_n  in  1  synchronous active-low reset.
REQ-006 In_Valid  in  1 / In_Ready  out  1  operand-pair handshake.
REQ-007 In_A, In_B  in  W  operand pair.
REQ-008 Gcd_Ain, Gcd_Bin  out  W  operands to the GCD engine.
REQ-009 Gcd_Start  out  1 / Gcd_Ack  out  1  engine start and acknowledge pulses.
REQ-010 Gcd_Done  in  1 / Gcd_Result  in  W  engine done-state flag and result.
REQ-011 Out_Valid  out  1 / Out_Ready  in  1  result handshake.
REQ-012 Out_A, Out_B, Out_Gcd  out  W  original pair and its GCD.
REQ-013 Out_Zero  out  1  result bypassed the engine (zero operand).
REQ-014 Busy  out  1 / Count  out  5  FSM not IDLE / FIFO occupancy.

Function
REQ-015 Pair SHALL be accepted on the rising edge where In_Valid && In_Ready; In_Ready = (Count != DEPTH).
REQ-016 A push while full SHALL be blocked even if a pop occurs in the same cycle. A push and a pop in the same cycle when not full SHALL leave Count unchanged.
REQ-017 FSM states SHALL be IDLE, START, WAIT, ACK, OUT; the encoding is one-hot.
REQ-018 IDLE -> START when Count != 0. On that edge, Gcd_Ain/Gcd_Bin SHALL be loaded from the FIFO head and held constant until ACK is left.
REQ-019 START SHALL assert Gcd_Start for exactly one cycle, then go to WAIT.
REQ-020 WAIT SHALL hold until Gcd_Done = 1, then capture Gcd_Result into Out_Gcd and go to ACK.
REQ-021 ACK SHALL assert Gcd_Ack for exactly one cycle and pop the FIFO head into Out_A/Out_B, then go to OUT.
REQ-022 OUT SHALL hold Out_Valid = 1 with stable data until Out_Ready = 1, then return to IDLE. There is no back-to-back overlap: the next START occurs no earlier than the cycle after the OUT handshake.
REQ-023 Gcd_Start and Gcd_Ack SHALL never be high in the same cycle; outside START/ACK respectively they SHALL be 0.
REQ-024 FIFO pointers SHALL wrap modulo DEPTH; Count SHALL saturate at neither 0 nor DEPTH, because guarded push/pop make overflow and underflow impossible.
REQ-025 An unreachable state SHALL return to IDLE on the next edge.

Reset
REQ-026 On a Reset_n = 0 edge: FSM SHALL go to IDLE; FIFO pointers and Count SHALL go to 0; all outputs SHALL go to 0 except In_Ready = 1.
REQ-027 A reset mid-operation (any state) SHALL discard all queued pairs and any in-flight result; no Gcd_Ack is issued.
REQ-028 The integrator SHALL drive the engine's active-high Reset from ~Reset_n.

Configuration
REQ-029 Macro GCD_SEQ_ZERO_GUARD_EN. When defined: in IDLE, if the head pair has In_A == 0 or In_B == 0, the FSM SHALL go directly to OUT with Gcd_Start never asserted.
REQ-030 Under GCD_SEQ_ZERO_GUARD_EN, the bypass result SHALL be Out_Gcd = max(A, B), the head SHALL be popped, and Out_Zero = 1.
REQ-031 When GCD_SEQ_ZERO_GUARD_EN is undefined: zero pairs SHALL be forwarded to the engine normally, and Out_Zero SHALL be tied 0.

Structure
REQ-032 Package gcd_seq_pkg SHALL hold the state localparams (IDLE..OUT one-hot), the default W, and the default DEPTH.
REQ-033 The FIFO SHALL be sub-module gcd_pair_fifo: 2W-bit data, DEPTH entries, push/pop/count ports. The FSM and output registers stay in gcd_sequencer.

Verification
REQ-034 Push (36,24) with a GCD engine attached, Out_Ready = 1 -> exactly one Gcd_Start pulse and one Gcd_Ack pulse; Out_Valid with Out_A = 36, Out_B = 24, Out_Gcd = 12.
REQ-035 Push (17,5), (48,18), (7,7), (200,120) back-to-back -> In_Ready = 0 after the 4th push while the first is busy; results are 1, 6, 7, 40 in order.
REQ-036 Out_Ready = 0 for 10 cycles during OUT -> Out_Valid and data stable for those cycles; no new Gcd_Start during them.
REQ-037 Reset_n = 0 for one cycle while in WAIT with 3 pairs queued -> next cycle: Count = 0, Busy = 0, Out_Valid = 0, In_Ready = 1.
REQ-038 With GCD_SEQ_ZERO_GUARD_EN, push (0,9) -> Out_Gcd = 9, Out_Zero = 1, Gcd_Start never asserted.
REQ-039 Without GCD_SEQ_ZERO_GUARD_EN, push (0,9) -> Gcd_Start asserted for that pair, Out_Zero = 0.

Source files
------------

// File: rtl/gcd_seq_pkg.sv
// Shared state encoding and defaults for the GCD sequencer.
// Optional zero-operand bypass is enabled by GCD_SEQ_ZERO_GUARD_EN.
package gcd_seq_pkg;

    localparam int GCD_W_DEF     = 8;
    localparam int GCD_DEPTH_DEF = 4;

    localparam logic [4:0] ST_IDLE  = 5'b00001;
    localparam logic [4:0] ST_START = 5'b00010;
    localparam logic [4:0] ST_WAIT  = 5'b00100;
    localparam logic [4:0] ST_ACK   = 5'b01000;
    localparam logic [4:0] ST_OUT   = 5'b10000;

    typedef enum logic [4:0] {
        S_IDLE  = ST_IDLE,
        S_START = ST_START,
        S_WAIT  = ST_WAIT,
        S_ACK   = ST_ACK,
        S_OUT   = ST_OUT
    } state_e;

endpackage

// File: rtl/gcd_sequencer_if.sv
// Operand, engine and result handshake bundle for gcd_sequencer.
// master = environment side, slave = sequencer side.
interface gcd_sequencer_if import gcd_seq_pkg::*; #(
    parameter int W = GCD_W_DEF
) ();

    logic         In_Valid;
    logic         In_Ready;
    logic [W-1:0] In_A;
    logic [W-1:0] In_B;
    logic [W-1:0] Gcd_Ain;
    logic [W-1:0] Gcd_Bin;
    logic         Gcd_Start;
    logic         Gcd_Ack;
    logic         Gcd_Done;
    logic [W-1:0] Gcd_Result;
    logic         Out_Valid;
    logic         Out_Ready;
    logic [W-1:0] Out_A;
    logic [W-1:0] Out_B;
    logic [W-1:0] Out_Gcd;
    logic         Out_Zero;
    logic         Busy;
    logic [4:0]   Count;

    modport master (
        output In_Valid, In_A, In_B,
        output Gcd_Done, Gcd_Result, Out_Ready,
        input  In_Ready, Gcd_Ain, Gcd_Bin,
        input  Gcd_Start, Gcd_Ack, Out_Valid,
        input  Out_A, Out_B, Out_Gcd, Out_Zero,
        input  Busy, Count
    );

    modport slave (
        input  In_Valid, In_A, In_B,
        input  Gcd_Done, Gcd_Result, Out_Ready,
        output In_Ready, Gcd_Ain, Gcd_Bin,
        output Gcd_Start, Gcd_Ack, Out_Valid,
        output Out_A, Out_B, Out_Gcd, Out_Zero,
        output Busy, Count
    );

endinterface

// File: rtl/gcd_pair_fifo.sv
// Operand-pair FIFO; caller guarantees no push when full, no pop when empty.
module gcd_pair_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 16
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          pop_i,
    output logic [DW-1:0] rdata_o,
    output logic [4:0]    count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [4:0]    cnt_q, cnt_d;

    // DEPTH is a power of two, so pointer overflow is the wrap
    always_comb begin
        wr_d  = wr_q + AW'(push_i);
        rd_d  = rd_q + AW'(pop_i);
        cnt_d = cnt_q + 5'(push_i) - 5'(pop_i);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/gcd_sequencer.sv
// Feeds queued operand pairs to an external GCD engine, one at a time.
// GCD_SEQ_ZERO_GUARD_EN: pairs with a zero operand bypass the engine.
module gcd_sequencer import gcd_seq_pkg::*; #(
    parameter int DEPTH = GCD_DEPTH_DEF,
    parameter int W     = GCD_W_DEF
) (
    input logic            Clk,
    input logic            Reset_n,
    gcd_sequencer_if.slave bus
);

    state_e       state_q, state_d;
    logic [W-1:0] ain_q, ain_d;
    logic [W-1:0] bin_q, bin_d;
    logic [W-1:0] oa_q, oa_d;
    logic [W-1:0] ob_q, ob_d;
    logic [W-1:0] og_q, og_d;
    logic         oz_q, oz_d;

    logic           full;
    logic           push;
    logic           pop;
    logic           zero_hit;
    logic [4:0]     count;
    logic [2*W-1:0] head;
    logic [W-1:0]   head_a;
    logic [W-1:0]   head_b;

    assign head_a = head[2*W-1:W];
    assign head_b = head[W-1:0];
    assign full   = (count == 5'(DEPTH));
    assign push   = bus.In_Valid && !full;

`ifdef GCD_SEQ_ZERO_GUARD_EN
    assign zero_hit = (head_a == '0) || (head_b == '0);
`else
    assign zero_hit = 1'b0;
`endif

    gcd_pair_fifo #(
        .DEPTH (DEPTH),
        .DW    (2*W)
    ) u_fifo (
        .clk_i   (Clk),
        .rst_ni  (Reset_n),
        .push_i  (push),
        .wdata_i ({bus.In_A, bus.In_B}),
        .pop_i   (pop),
        .rdata_o (head),
        .count_o (count)
    );

    always_comb begin
        state_d = state_q;
        ain_d   = ain_q;
        bin_d   = bin_q;
        oa_d    = oa_q;
        ob_d    = ob_q;
        og_d    = og_q;
        oz_d    = oz_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count != 5'd0) begin
                    if (zero_hit) begin
                        // gcd(x,0) = x, so max() is the answer
                        pop     = 1'b1;
                        oa_d    = head_a;
                        ob_d    = head_b;
                        og_d    = (head_a > head_b) ? head_a : head_b;
                        oz_d    = 1'b1;
                        state_d = S_OUT;
                    end else begin
                        ain_d   = head_a;
                        bin_d   = head_b;
                        state_d = S_START;
                    end
                end
            end
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (bus.Gcd_Done) begin
                    og_d    = bus.Gcd_Result;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                pop     = 1'b1;
                oa_d    = head_a;
                ob_d    = head_b;
                oz_d    = 1'b0;
                state_d = S_OUT;
            end
            S_OUT: begin
                if (bus.Out_Ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            ain_q   <= '0;
            bin_q   <= '0;
            oa_q    <= '0;
            ob_q    <= '0;
            og_q    <= '0;
            oz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ain_q   <= ain_d;
            bin_q   <= bin_d;
            oa_q    <= oa_d;
            ob_q    <= ob_d;
            og_q    <= og_d;
            oz_q    <= oz_d;
        end
    end

    assign bus.In_Ready  = !full;
    assign bus.Gcd_Ain   = ain_q;
    assign bus.Gcd_Bin   = bin_q;
    assign bus.Gcd_Start = (state_q == S_START);
    assign bus.Gcd_Ack   = (state_q == S_ACK);
    assign bus.Out_Valid = (state_q == S_OUT);
    assign bus.Out_A     = oa_q;
    assign bus.Out_B     = ob_q;
    assign bus.Out_Gcd   = og_q;
    assign bus.Out_Zero  = oz_q;
    assign bus.Busy      = (state_q != S_IDLE);
    assign bus.Count     = count;

endmodule

// File: tb/tb_gcd_sequencer.sv
// Bench for gcd_sequencer: behavioural GCD engine, queue-based result model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_gcd_sequencer;
    import gcd_seq_pkg::*;

    localparam int W     = 8;
    localparam int DEPTH = 4;
`ifdef GCD_SEQ_ZERO_GUARD_EN
    localparam bit ZG = 1'b1;
`else
    localparam bit ZG = 1'b0;
`endif

    logic Clk;
    logic Reset_n;

    gcd_sequencer_if #(.W(W)) bus ();

    gcd_sequencer #(
        .DEPTH (DEPTH),
        .W     (W)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    typedef struct {
        int a;
        int b;
        int g;
        bit z;
    } res_t;

    int   tests;
    int   fails;
    bit   chk_en;
    res_t exp_q[$];
    int   got_q[$];
    int   pushed;
    int   done_n;
    int   n_start;
    int   n_ack;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic int gcd_ref(int a, int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic chk(string nm, int act, int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    // GCD engine: latches operands on Start, raises Done after a
    // pair-dependent delay, holds Done until Ack.
    int e_cnt;
    bit e_busy;
    int e_a;
    int e_b;
    initial begin
        bus.Gcd_Done   = 1'b0;
        bus.Gcd_Result = '0;
        e_busy = 1'b0;
        e_cnt  = 0;
        forever begin
            @(negedge Clk);
            if (!Reset_n) begin
                bus.Gcd_Done = 1'b0;
                e_busy = 1'b0;
            end else if (bus.Gcd_Ack) begin
                bus.Gcd_Done = 1'b0;
                e_busy = 1'b0;
            end else if (bus.Gcd_Start) begin
                e_a    = int'(bus.Gcd_Ain);
                e_b    = int'(bus.Gcd_Bin);
                e_cnt  = 2 + (e_a % 3);
                e_busy = 1'b1;
                bus.Gcd_Done = 1'b0;
            end else if (e_busy && !bus.Gcd_Done) begin
                e_cnt--;
                if (e_cnt == 0) begin
                    bus.Gcd_Result = W'(gcd_ref(e_a, e_b));
                    bus.Gcd_Done   = 1'b1;
                end
            end
        end
    end

    // Compare, then advance the model for the coming edge.
    always @(negedge Clk) begin
        if (chk_en) begin
            chk("start_ack_overlap",
                int'(bus.Gcd_Start && bus.Gcd_Ack), 0);
            chk("count", int'(bus.Count),
                pushed - done_n - int'(bus.Out_Valid));
            chk("in_ready", int'(bus.In_Ready),
                int'(bus.Count != 5'(DEPTH)));
            if (bus.Out_Valid) begin
                chk("out_has_exp", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    chk("out_a", int'(bus.Out_A), exp_q[0].a);
                    chk("out_b", int'(bus.Out_B), exp_q[0].b);
                    chk("out_gcd", int'(bus.Out_Gcd), exp_q[0].g);
                    chk("out_zero", int'(bus.Out_Zero),
                        int'(exp_q[0].z));
                end
            end
            if (bus.Gcd_Start) begin
                chk("start_has_exp", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    chk("gcd_ain", int'(bus.Gcd_Ain), exp_q[0].a);
                    chk("gcd_bin", int'(bus.Gcd_Bin), exp_q[0].b);
                end
            end
            if (!Reset_n) begin
                exp_q.delete();
                pushed  = 0;
                done_n  = 0;
                n_start = 0;
                n_ack   = 0;
            end else begin
                if (bus.Gcd_Start) n_start++;
                if (bus.Gcd_Ack) n_ack++;
                if (bus.Out_Valid && bus.Out_Ready
                    && exp_q.size() > 0) begin
                    chk("starts_per_pair", n_start,
                        exp_q[0].z ? 0 : 1);
                    chk("acks_per_pair", n_ack,
                        exp_q[0].z ? 0 : 1);
                    got_q.push_back(int'(bus.Out_Gcd));
                    void'(exp_q.pop_front());
                    done_n++;
                    n_start = 0;
                    n_ack   = 0;
                end
                if (bus.In_Valid && bus.In_Ready) begin
                    res_t r;
                    r.a = int'(bus.In_A);
                    r.b = int'(bus.In_B);
                    r.z = ZG && (r.a == 0 || r.b == 0);
                    r.g = r.z ? ((r.a > r.b) ? r.a : r.b)
                              : gcd_ref(r.a, r.b);
                    exp_q.push_back(r);
                    pushed++;
                end
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic push(int a, int b);
        bit ok;
        ok = 1'b0;
        bus.In_Valid = 1'b1;
        bus.In_A = W'(a);
        bus.In_B = W'(b);
        for (int k = 0; k < 200 && !ok; k++) begin
            ok = bus.In_Ready;
            step();
        end
        bus.In_Valid = 1'b0;
        chk("push_accepted", int'(ok), 1);
    endtask

    task automatic wait_got(int n);
        int k;
        k = 0;
        while (got_q.size() < n && k < 300) begin
            step();
            k++;
        end
        chk("wait_results", int'(got_q.size() >= n), 1);
    endtask

    initial begin
        int k;
        int starts;
        int acks;
        int nget;
        tests = 0;
        fails = 0;
        chk_en = 1'b0;
        pushed = 0;
        done_n = 0;
        n_start = 0;
        n_ack = 0;
        Reset_n = 1'b0;
        bus.In_Valid = 1'b0;
        bus.In_A = '0;
        bus.In_B = '0;
        bus.Out_Ready = 1'b0;
        repeat (3) step();

        chk("rst_in_ready", int'(bus.In_Ready), 1);
        chk("rst_count", int'(bus.Count), 0);
        chk("rst_busy", int'(bus.Busy), 0);
        chk("rst_out_valid", int'(bus.Out_Valid), 0);
        chk("rst_start", int'(bus.Gcd_Start), 0);
        chk("rst_ack", int'(bus.Gcd_Ack), 0);
        chk("rst_out_gcd", int'(bus.Out_Gcd), 0);
        Reset_n = 1'b1;
        chk_en = 1'b1;
        step();

        // single pair
        bus.Out_Ready = 1'b1;
        push(36, 24);
        wait_got(1);
        chk("lit_36_24", got_q[0], 12);

        // back-to-back fill
        push(17, 5);
        push(48, 18);
        push(7, 7);
        push(200, 120);
        chk("full_in_ready", int'(bus.In_Ready), 0);
        chk("full_count", int'(bus.Count), 4);
        wait_got(5);
        chk("lit_17_5", got_q[1], 1);
        chk("lit_48_18", got_q[2], 6);
        chk("lit_7_7", got_q[3], 7);
        chk("lit_200_120", got_q[4], 40);

        // output backpressure
        bus.Out_Ready = 1'b0;
        push(90, 60);
        push(14, 21);
        k = 0;
        while (!bus.Out_Valid && k < 100) begin
            step();
            k++;
        end
        chk("stall_reached_out", int'(bus.Out_Valid), 1);
        starts = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            starts += int'(bus.Gcd_Start);
            chk("stall_valid", int'(bus.Out_Valid), 1);
            chk("stall_gcd", int'(bus.Out_Gcd), 30);
        end
        chk("stall_no_start", starts, 0);
        bus.Out_Ready = 1'b1;
        wait_got(7);
        chk("lit_90_60", got_q[5], 30);
        chk("lit_14_21", got_q[6], 7);

        // reset while waiting on the engine
        push(100, 75);
        push(81, 27);
        push(64, 48);
        chk("pre_rst_count", int'(bus.Count), 3);
        chk("pre_rst_wait", int'(bus.Busy && !bus.Gcd_Start
                                  && !bus.Gcd_Ack
                                  && !bus.Out_Valid), 1);
        Reset_n = 1'b0;
        step();
        chk("mid_rst_count", int'(bus.Count), 0);
        chk("mid_rst_busy", int'(bus.Busy), 0);
        chk("mid_rst_out_valid", int'(bus.Out_Valid), 0);
        chk("mid_rst_in_ready", int'(bus.In_Ready), 1);
        chk("mid_rst_out_a", int'(bus.Out_A), 0);
        chk("mid_rst_ain", int'(bus.Gcd_Ain), 0);
        Reset_n = 1'b1;
        nget = got_q.size();
        acks = 0;
        starts = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            acks += int'(bus.Gcd_Ack);
            starts += int'(bus.Gcd_Start);
        end
        chk("post_rst_no_ack", acks, 0);
        chk("post_rst_no_start", starts, 0);
        chk("post_rst_no_result", got_q.size(), nget);

        // zero operand
        push(0, 9);
        wait_got(nget + 1);
        chk("lit_0_9", got_q[nget], 9);
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
